alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin controller that shares one `ALU` instance (32-bit add / 32×32 multiply, `selector` 0 = add, 1 = multiply) between two requesters. It accepts one operation at a time over a valid/ready handshake and holds the ALU operands stable for a programmable number of cycles, so the combinational adder and multiplier can be timed as multicycle paths. It then captures `Result`/`carry` into a register and returns them to the originating requester over a valid/ready response channel. It sits between the requesting masters and the `ALU`; the `ALU` is instantiated outside this block and connected through the `alu_*` ports.

## Interface
- `ADD_CYCLES`, default 1: cycles the operands are held before capturing an add result; must be ≥1.
- `MUL_CYCLES`, default 4: cycles the operands are held before capturing a multiply result; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending from requester 0/1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req1_a`  in  32  operand A.
- `req0_b`, `req1_b`  in  32  operand B.
- `req0_sel`, `req1_sel`  in  1  0 = add, 1 = multiply.
- `resp0_valid`, `resp1_valid`  out  1  response available for requester 0/1.
- `resp0_ready`, `resp1_ready`  in  1  requester consumes the response.
- `resp_result`  out  64  captured ALU result, shared by both response channels.
- `resp_carry`  out  1  captured ALU carry, shared by both response channels.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_selector`  out  1  registered op select to the ALU.
- `alu_result`  in  64  ALU `Result`.
- `alu_carry`  in  1  ALU `carry`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among asserted `reqN_valid`.
  - Only one requester valid: that requester wins.
  - Both valid: the requester not in `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` is combinational: high only for the winner, and only in IDLE.
  - On handshake (valid & ready):
    - latch the winner's a/b/sel into `alu_a`/`alu_b`/`alu_selector`;
    - record `owner` = winner and set `last_grant` = winner;
    - load the cycle counter with (sel ? `MUL_CYCLES` : `ADD_CYCLES`) − 1;
    - go to EXEC.
- **EXEC**
  - `alu_*` outputs are held constant.
  - Counter decrements each cycle.
  - On the cycle the counter reads 0:
    - register `alu_result` into `resp_result` and `alu_carry` into `resp_carry`;
    - go to RESP.
- **RESP**
  - `resp<owner>_valid` = 1; the other `respN_valid` = 0.
  - `resp_result`/`resp_carry` are held.
  - When `resp<owner>_ready` = 1, the response is consumed and the FSM goes to IDLE.
  - `alu_*` outputs keep their last value; they are not cleared.
- No request is accepted in EXEC or RESP; both `reqN_ready` are 0 there.
- A requester may drop `req_valid` before acceptance. Arbitration is re-evaluated every IDLE cycle and no state changes.
- Width rules: results are passed through unmodified.
  - Add: `resp_result[63:32]` = 0 and `resp_carry` = adder carry-out.
  - Multiply: full 64-bit product and `resp_carry` = 0.
- `respN_ready` asserted while `respN_valid` = 0 is ignored.

## Timing
- Reset (asynchronous, `rst_n` low):
  - state = IDLE;
  - `alu_a`, `alu_b`, `resp_result` = 0;
  - `alu_selector`, `resp_carry`, `busy`, all `resp*_valid` = 0;
  - `last_grant` = 1.
- Reset asserted mid-operation aborts the in-flight op. No response is produced, and the first cycle after release is IDLE.
- Handshake at edge T (IDLE): `alu_*` are valid after T.
- EXEC lasts exactly N cycles (N = `ADD_CYCLES` or `MUL_CYCLES`). `resp_result` is captured at edge T+N.
- `resp_valid` is high from cycle T+N onward. Request-to-response latency is N+1 cycles, including the accept cycle.
- Response consumed at edge R:
  - the FSM is in IDLE during cycle R+1 and can accept a request in that cycle;
  - minimum back-to-back issue interval is N+2 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…

## Test plan
- Reset then single add on port 0, A=0xFFFFFFFF, B=0x00000001, `ADD_CYCLES`=1 -> `resp0_valid` 2 cycles after accept, `resp_result`=64'h0, `resp_carry`=1; `resp1_valid` stays 0.
- Multiply on port 1, A=B=0xFFFFFFFF, `MUL_CYCLES`=4 -> `alu_*` stable for 4 EXEC cycles, `resp1_valid` 5 cycles after accept, `resp_result`=64'hFFFFFFFE00000001, `resp_carry`=0.
- Both ports continuously valid, four ops each, `resp*_ready` tied 1 -> grant order 0,1,0,1,0,1,0,1, each result matches its own operands, `req*_ready` never high outside IDLE.
- Backpressure: hold `resp0_ready`=0 for 10 cycles in RESP -> `resp0_valid` and `resp_result` stable, `busy`=1, `req1_ready`=0 throughout; release -> IDLE next cycle.
- `rst_n` pulsed low during EXEC of a multiply -> all outputs 0 immediately, no response after release, next request (add 3+4) returns 64'h7, carry 0.
- Requester 0 raises then drops `req0_valid` while FSM is in RESP -> no acceptance, `last_grant` unchanged, subsequent port-1 request granted normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of alu_arbiter, bundled so the
// arbiter and its requesters share one connection.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_sel;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_sel;
  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [63:0] resp_result;
  logic        resp_carry;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_selector;
  logic [63:0] alu_result;
  logic        alu_carry;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_carry,
    input  resp0_ready, resp1_ready,
    output alu_a, alu_b, alu_selector,
    input  alu_result, alu_carry,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_carry,
    output resp0_ready, resp1_ready,
    input  alu_a, alu_b, alu_selector,
    output alu_result, alu_carry,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external add/multiply ALU between two requesters,
// holding operands for a per-operation number of cycles before capturing the result.
module alu_arbiter #(
  parameter int ADD_CYCLES = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > ADD_CYCLES) ? MUL_CYCLES : ADD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ADD_LOAD = CNT_W'(ADD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_r;
  logic             last_grant_r;
  logic [31:0]      alu_a_r;
  logic [31:0]      alu_b_r;
  logic             alu_sel_r;
  logic [63:0]      result_r;
  logic             carry_r;

  logic             winner_s;
  logic             accept_s;
  logic             resp_fire_s;
  logic [31:0]      win_a_s;
  logic [31:0]      win_b_s;
  logic             win_sel_s;

  // Arbitration and handshake decode; a tie goes to the requester not granted last.
  always_comb begin
    winner_s    = 1'b0;
    win_a_s     = bus.req0_a;
    win_b_s     = bus.req0_b;
    win_sel_s   = bus.req0_sel;
    if (bus.req0_valid && bus.req1_valid) begin
      winner_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (winner_s) begin
      win_a_s   = bus.req1_a;
      win_b_s   = bus.req1_b;
      win_sel_s = bus.req1_sel;
    end else begin
      win_a_s   = bus.req0_a;
      win_b_s   = bus.req0_b;
      win_sel_s = bus.req0_sel;
    end
    accept_s    = (state_r == IDLE) && (bus.req0_valid || bus.req1_valid);
    resp_fire_s = (state_r == RESP) && (owner_r ? bus.resp1_ready : bus.resp0_ready);
  end

  assign bus.req0_ready   = accept_s & ~winner_s;
  assign bus.req1_ready   = accept_s & winner_s;
  assign bus.resp0_valid  = (state_r == RESP) & ~owner_r;
  assign bus.resp1_valid  = (state_r == RESP) & owner_r;
  assign bus.resp_result  = result_r;
  assign bus.resp_carry   = carry_r;
  assign bus.alu_a        = alu_a_r;
  assign bus.alu_b        = alu_b_r;
  assign bus.alu_selector = alu_sel_r;
  assign bus.busy         = (state_r != IDLE);

  // Operation sequencing: accept, hold operands for the multicycle window, return result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_sel_r    <= 1'b0;
      result_r     <= 64'd0;
      carry_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r      <= win_a_s;
            alu_b_r      <= win_b_s;
            alu_sel_r    <= win_sel_s;
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
            cnt_r        <= win_sel_s ? MUL_LOAD : ADD_LOAD;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            result_r <= bus.alu_result;
            carry_r  <= bus.alu_carry;
            state_r  <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_fire_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single operations plus
// hand-written tie, reset-abort and fairness sequences, with a response scoreboard.
module tb_alu_arbiter;
  localparam int ADD_N = 1;
  localparam int MUL_N = 4;

  logic clk = 1'b0;
  logic rst_n;

  alu_arbiter_if bus();

  alu_arbiter #(.ADD_CYCLES(ADD_N), .MUL_CYCLES(MUL_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ALU model
  logic [32:0] alu_sum;
  assign alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_result = bus.alu_selector ? ({32'd0, bus.alu_a} * {32'd0, bus.alu_b})
                                           : {32'd0, alu_sum[31:0]};
  assign bus.alu_carry  = bus.alu_selector ? 1'b0 : alu_sum[32];

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [63:0] exp_res;
    logic        exp_c;
    int          hold;
    logic        poke;
  } vec_t;

  typedef struct {
    logic        port;
    logic [63:0] res;
    logic        c;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   grant_q[$];
  logic [1:0] acc_seen;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [64:0] golden(input logic [31:0] a, input logic [31:0] b, input logic sel);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sel) return {1'b0, {32'd0, a} * {32'd0, b}};
    else     return {s[32], 32'd0, s[31:0]};
  endfunction

  function automatic logic [31:0] fa(input int p, input int k);
    return 32'hFFFF_FFF0 + 32'(k) + 32'(p * 8);
  endfunction

  function automatic logic [31:0] fb(input int p, input int k);
    return 32'h0000_0020 + 32'(k * 3) + 32'(p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic resp_v(input logic p);
    return p ? bus.resp1_valid : bus.resp0_valid;
  endfunction

  function automatic logic req_rdy(input logic p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic sel);
    if (p) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end
  endtask

  task automatic set_resp_ready(input logic p, input logic v);
    if (p) bus.resp1_ready = v;
    else   bus.resp0_ready = v;
  endtask

  // Observe handshakes mid-cycle: push expectations on accept, pop and compare on response.
  task automatic monitor();
    logic [64:0] g;
    logic [1:0]  rv;
    logic [1:0]  rr;
    sb_t         e;
    acc_seen = 2'b00;
    if (bus.req0_valid && bus.req0_ready) begin
      acc_seen[0] = 1'b1;
      g = golden(bus.req0_a, bus.req0_b, bus.req0_sel);
      sb_q.push_back('{port: 1'b0, res: g[63:0], c: g[64]});
      grant_q.push_back(0);
    end
    if (bus.req1_valid && bus.req1_ready) begin
      acc_seen[1] = 1'b1;
      g = golden(bus.req1_a, bus.req1_b, bus.req1_sel);
      sb_q.push_back('{port: 1'b1, res: g[63:0], c: g[64]});
      grant_q.push_back(1);
    end
    if (bus.req0_ready || bus.req1_ready) chk("ready_only_idle", {63'd0, bus.busy}, 64'd0);
    chk("resp_exclusive", {63'd0, bus.resp0_valid & bus.resp1_valid}, 64'd0);
    rv = {bus.resp1_valid, bus.resp0_valid};
    rr = {bus.resp1_ready, bus.resp0_ready};
    for (int p = 0; p < 2; p++) begin
      if (rv[p] && rr[p]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: port %0d responded, required no response", p);
        end else begin
          e = sb_q.pop_front();
          chk("sb_port", 64'(p), {63'd0, e.port});
          chk("sb_result", bus.resp_result, e.res);
          chk("sb_carry", {63'd0, bus.resp_carry}, {63'd0, e.c});
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic p);
    int i;
    i = 0;
    do begin
      cyc();
      i++;
    end while (!acc_seen[p] && i < 20);
    chk("accept", {63'd0, acc_seen[p]}, 64'd1);
  endtask

  task automatic drain();
    int i;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    i = 0;
    while ((bus.busy || sb_q.size() != 0) && i < 40) begin
      cyc();
      i++;
    end
    chk("drain_done", {63'd0, bus.busy}, 64'd0);
    chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int n;
    n = v.sel ? MUL_N : ADD_N;
    set_req(v.port, 1'b1, v.a, v.b, v.sel);
    wait_accept(v.port);
    set_req(v.port, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < n; k++) begin
      chk("exec_alu_a", {32'd0, bus.alu_a}, {32'd0, v.a});
      chk("exec_alu_b", {32'd0, bus.alu_b}, {32'd0, v.b});
      chk("exec_alu_sel", {63'd0, bus.alu_selector}, {63'd0, v.sel});
      chk("exec_busy", {63'd0, bus.busy}, 64'd1);
      chk("exec_no_resp", {63'd0, resp_v(v.port)}, 64'd0);
      cyc();
    end
    chk("resp_valid", {63'd0, resp_v(v.port)}, 64'd1);
    chk("resp_other_low", {63'd0, resp_v(~v.port)}, 64'd0);
    chk("resp_result", bus.resp_result, v.exp_res);
    chk("resp_carry", {63'd0, bus.resp_carry}, {63'd0, v.exp_c});
    for (int h = 0; h < v.hold; h++) begin
      if (v.poke) set_req(~v.port, (h < v.hold - 1), 32'd5, 32'd6, 1'b0);
      cyc();
      chk("hold_valid", {63'd0, resp_v(v.port)}, 64'd1);
      chk("hold_result", bus.resp_result, v.exp_res);
      chk("hold_busy", {63'd0, bus.busy}, 64'd1);
      chk("hold_other_ready", {63'd0, req_rdy(~v.port)}, 64'd0);
    end
    if (v.poke) set_req(~v.port, 1'b0, 32'd0, 32'd0, 1'b0);
    set_resp_ready(v.port, 1'b1);
    cyc();
    set_resp_ready(v.port, 1'b0);
    chk("release_idle", {63'd0, bus.busy}, 64'd0);
    chk("release_no_valid", {63'd0, resp_v(v.port)}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0;
    int done1;
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0,                    1'b1, 0,  1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001,  1'b0, 0,  1'b0};
    vecs[2] = '{1'b0, 32'h8000_0001, 32'h8000_0000, 1'b0, 64'h0000_0000_0000_0001,  1'b1, 0,  1'b0};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 64'h0000_0000_2345_6789,  1'b0, 0,  1'b0};
    vecs[4] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000,  1'b0, 0,  1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0001_FFFF_FFFE,  1'b0, 10, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0005, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_000B,  1'b0, 3,  1'b1};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 64'h0,                    1'b0, 0,  1'b0};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    acc_seen = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("rst_alu_b", {32'd0, bus.alu_b}, 64'd0);
    chk("rst_alu_sel", {63'd0, bus.alu_selector}, 64'd0);
    chk("rst_result", bus.resp_result, 64'd0);
    chk("rst_carry", {63'd0, bus.resp_carry}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Table of single operations, including backpressure and the drop-in-RESP case
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Tie after port 1 was granted last: port 0 must win
    set_req(1'b0, 1'b1, 32'd10, 32'd20, 1'b0);
    set_req(1'b1, 1'b1, 32'd7, 32'd8, 1'b1);
    wait_accept(1'b0);
    chk("tie_winner", {62'd0, acc_seen}, 64'd1);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Reset in the middle of a multiply aborts it without a response
    set_req(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_accept(1'b1);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc();
    cyc();
    chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("abort_alu_b", {32'd0, bus.alu_b}, 64'd0);
    chk("abort_alu_sel", {63'd0, bus.alu_selector}, 64'd0);
    chk("abort_result", bus.resp_result, 64'd0);
    chk("abort_carry", {63'd0, bus.resp_carry}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("post_abort_idle", {63'd0, bus.busy}, 64'd0);
    end
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    run_op('{1'b0, 32'd3, 32'd4, 1'b0, 64'h7, 1'b0, 0, 1'b0});

    // Fairness: both continuously valid from reset, four ops each
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_q.delete();
    sb_q.delete();
    done0 = 0;
    done1 = 0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    set_req(1'b0, 1'b1, fa(0, 0), fb(0, 0), 1'b0);
    set_req(1'b1, 1'b1, fa(1, 0), fb(1, 0), 1'b1);
    for (int c = 0; c < 200 && (done0 + done1) < 8; c++) begin
      cyc();
      if (acc_seen[0]) begin
        done0++;
        set_req(1'b0, (done0 < 4), fa(0, done0), fb(0, done0), 1'(done0 % 2));
      end
      if (acc_seen[1]) begin
        done1++;
        set_req(1'b1, (done1 < 4), fa(1, done1), fb(1, done1), 1'((done1 + 1) % 2));
      end
    end
    chk("fair_count", 64'(done0 + done1), 64'd8);
    for (int i = 0; i < grant_q.size(); i++) chk("grant_order", 64'(grant_q[i]), 64'(i % 2));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
